serial_add_arbiter: RTL and testbench
=====================================

Name: serial_add_arbiter

Overview:
- Shares one bit-serial full-adder datapath between two requesters.
- Round-robin arbitration picks the requester. The block latches that requester's operands and drives one full_adder instance LSB-first for WIDTH cycles with a registered carry.
- It then presents sum, carry-out and requester ID on a valid/ready output port.
- It sits between client logic and the single shared full_adder cell, trading throughput for area.

Parameters:
- WIDTH, 8, operand/sum width in bits (legal range 1 to 64).
- CNT_W, $clog2(WIDTH+1), bit counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req0_valid  input  1  requester 0 has an operand pair
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req0_cin  input  1  requester 0 carry-in
- req0_ready  output  1  block accepts requester 0 this cycle
- req1_valid  input  1  requester 1 has an operand pair
- req1_a  input  WIDTH  requester 1 operand A
- req1_b  input  WIDTH  requester 1 operand B
- req1_cin  input  1  requester 1 carry-in
- req1_ready  output  1  block accepts requester 1 this cycle
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_sum  output  WIDTH  a+b+cin modulo 2^WIDTH
- out_cout  output  1  carry out of bit WIDTH-1
- out_id  output  1  requester that owns the result
- busy  output  1  high in ADD or DONE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; out_valid=0, out_sum=0, out_cout=0, out_id=0, busy=0; carry register=0; bit counter=0; last_grant=1, so req0 wins first.
- IDLE state:
  - reqN_ready is combinational and asserted only for the arbitration winner; both are low outside IDLE.
  - Winner when only one valid: that requester.
  - Winner when both valid: the requester not equal to last_grant.
  - Winner when neither valid: none; both ready low.
- Accept: the handshake reqN_valid&reqN_ready happens at edge T.
  - Latch a, b into shift registers; carry reg = cin; id = N; last_grant = N; counter = 0; go to ADD.
- ADD state (cycles T+1 .. T+WIDTH):
  - Each cycle, full_adder gets a_sh[0], b_sh[0] and the carry reg.
  - Its sum shifts into the MSB of the sum shift register, while a_sh and b_sh shift right. Its cout is loaded into the carry reg.
  - The counter increments. When the counter reaches WIDTH-1, the next state is DONE.
  - After WIDTH shifts, bit 0 sits at the LSB.
- DONE state (from T+WIDTH+1):
  - out_valid=1; out_sum, out_cout (= final carry reg) and out_id are stable.
  - Outputs hold while out_ready=0; no new request is accepted.
  - On out_valid&out_ready: out_valid drops next cycle and the state returns to IDLE.
  - The first new accept is possible in the cycle after the result is taken.
- Latency: accept edge to out_valid = WIDTH+1 cycles. Minimum spacing between accepts = WIDTH+2 cycles.
- busy=1 in ADD and DONE, 0 in IDLE.
- Operand inputs are sampled only at accept; later changes are ignored. Valids may drop without a handshake (no commitment).
- Arithmetic: out_sum = (a+b+cin)[WIDTH-1:0], out_cout = bit WIDTH. 0xFF..F + 0 + 1 wraps to 0 with cout=1.
- Reset mid-ADD or mid-DONE: the next cycle is IDLE, all registers take reset values, the partial result is discarded and out_valid never pulses.
- A reset cycle that coincides with a handshake: the request is not accepted.
- WIDTH=1: ADD lasts exactly one cycle.

Test Plan:
- WIDTH=8, req0 alone, a=0xFF, b=0x01, cin=0, out_ready=1 -> req0_ready=1 at accept; out_valid exactly 9 cycles later with out_sum=0x00, out_cout=1, out_id=0.
- req1 alone, a=0x7F, b=0x00, cin=1 -> out_sum=0x80, out_cout=0, out_id=1.
- From reset, both valid continuously with distinct operands -> grants alternate 0,1,0,1. Each result's id and sum match its requester, and the other ready stays low during each grant.
- out_ready held low 5 cycles after out_valid -> out_sum, out_cout and out_id stable; both reqN_ready=0. Raise out_ready -> out_valid falls next cycle, and the next accept occurs one cycle after that.
- rst asserted at the 4th ADD cycle -> next cycle busy=0, out_valid=0, state IDLE. out_valid never asserts for the aborted op, and last_grant=1, so req0 wins the next conflict.
- Randomized 1000 ops against a+b+cin reference model with random out_ready stalls -> zero mismatches, latency always WIDTH+1.

Source files
------------

// File: rtl/serial_add_arbiter_if.sv
// Bundle of the two requester ports, the result port and the busy flag of serial_add_arbiter.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid may drop without a transfer.
interface serial_add_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
    logic             req1_ready;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_id;
    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_sum, out_cout, out_id, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_sum, out_cout, out_id, busy
    );
endinterface

// File: rtl/serial_add_arbiter.sv
// Two requesters share one bit-serial full adder: round-robin grant, WIDTH LSB-first add cycles,
// then the result is held on a valid/ready port until taken.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_arbiter #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_add_arbiter_if.slave   bus,
    output logic [1:0]            dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             id;
    logic             last_grant;
    logic             grant0;
    logic             grant1;
    logic             fa_s;
    logic             fa_cout;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // On a conflict the requester that did not win last time gets the grant.
    always_comb begin
        state_n = state;
        grant0  = 1'b0;
        grant1  = 1'b0;
        case (state)
            IDLE: begin
                grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
                grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
                if (grant0 | grant1) state_n = ADD;
            end
            ADD: begin
                if (cnt == CNT_W'(WIDTH - 1)) state_n = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            sum_sh     <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            id         <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        a_sh       <= grant1 ? bus.req1_a : bus.req0_a;
                        b_sh       <= grant1 ? bus.req1_b : bus.req0_b;
                        carry      <= grant1 ? bus.req1_cin : bus.req0_cin;
                        id         <= grant1;
                        last_grant <= grant1;
                        cnt        <= '0;
                    end
                end
                ADD: begin
                    // Sum bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                    carry  <= fa_cout;
                    cnt    <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.out_valid  = (state == DONE);
    assign bus.out_sum    = sum_sh;
    assign bus.out_cout   = carry;
    assign bus.out_id     = id;
    assign bus.busy       = (state != IDLE);
    assign dbg_state      = state;
endmodule

// File: tb/tb_serial_add_arbiter.sv
// Bench for serial_add_arbiter: vector table, hand sequences for stall/reset/alternation,
// and a randomized run, all checked against a cycle-level reference model with a result queue.
module tb_serial_add_arbiter;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    serial_add_arbiter_if #(.WIDTH(W)) bus ();

    serial_add_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [W+1:0] exp_q[$];
    int           cyc      = 0;
    int           acc_cyc  = 0;
    int           ops_done = 0;
    logic         m_busy   = 1'b0;
    logic         m_lg     = 1'b1;
    logic         m_g0, m_g1, m_done;
    logic [W:0]   m_res;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 1'b0;
            m_lg   = 1'b1;
            exp_q.delete();
        end else begin
            m_done = m_busy && ((cyc - acc_cyc) >= W + 1);
            m_g0   = !m_busy && bus.req0_valid && (!bus.req1_valid || m_lg);
            m_g1   = !m_busy && bus.req1_valid && (!bus.req0_valid || !m_lg);
            check("req0_ready", bus.req0_ready, m_g0);
            check("req1_ready", bus.req1_ready, m_g1);
            check("out_valid", bus.out_valid, m_done);
            check("busy", bus.busy, m_busy);
            if (m_done) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL scoreboard: result present, expected queue empty");
                end else begin
                    check("result", {bus.out_id, bus.out_cout, bus.out_sum}, exp_q[0]);
                end
                if (bus.out_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    ops_done++;
                    m_busy = 1'b0;
                end
            end
            if (m_g0 || m_g1) begin
                if (m_g1) m_res = (W+1)'(bus.req1_a) + (W+1)'(bus.req1_b) + (W+1)'(bus.req1_cin);
                else      m_res = (W+1)'(bus.req0_a) + (W+1)'(bus.req0_b) + (W+1)'(bus.req0_cin);
                exp_q.push_back({m_g1, m_res});
                m_busy  = 1'b1;
                acc_cyc = cyc;
                m_lg    = m_g1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        if (n == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
        end
    endtask

    task automatic drop_reqs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a = W'($urandom); bus.req0_b = W'($urandom); bus.req0_cin = 1'($urandom);
        bus.req1_a = W'($urandom); bus.req1_b = W'($urandom); bus.req1_cin = 1'($urandom);
    endtask

    task automatic wait_accept(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (n == 0) ok = bus.req0_valid && bus.req0_ready;
            else        ok = bus.req1_valid && bus.req1_ready;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: requester %0d got no ready in 40 cycles, expected a grant", n);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = bus.out_valid;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL valid_timeout: out_valid low for 40 cycles, expected a result");
        end
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    localparam int NV = 8;
    vec_t tv[NV];

    initial begin
        bit ok;
        int t_acc;
        int target;

        tv[0] = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tv[1] = '{1, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        tv[2] = '{0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        tv[3] = '{1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tv[4] = '{0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tv[5] = '{1, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
        tv[6] = '{0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tv[7] = '{1, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

        bus.out_ready = 1'b1;
        drop_reqs();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_out_sum", bus.out_sum, '0);
        check("rst_out_cout", bus.out_cout, 1'b0);
        check("rst_out_id", bus.out_id, 1'b0);
        check("rst_state", dbg_state, 2'd0);

        // Single-requester vectors, result taken immediately.
        for (int i = 0; i < NV; i++) begin
            step();
            drive_req(tv[i].id, tv[i].a, tv[i].b, tv[i].cin);
            wait_accept(tv[i].id, ok);
            t_acc = cyc;
            step();
            drop_reqs();
            wait_valid(ok);
            if (ok) begin
                check("vec_latency", cyc - t_acc, W + 1);
                check("vec_sum", bus.out_sum, tv[i].sum);
                check("vec_cout", bus.out_cout, tv[i].cout);
                check("vec_id", bus.out_id, tv[i].id);
            end
        end

        // Both requesting continuously from reset: grants alternate 0,1,0,1.
        do_reset();
        drive_req(0, 8'h10, 8'h20, 1'b0);
        drive_req(1, 8'hF0, 8'h20, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_valid(ok);
            if (ok) begin
                check("alt_id", bus.out_id, k % 2);
                check("alt_sum", bus.out_sum, (k % 2) ? 8'h11 : 8'h30);
                check("alt_cout", bus.out_cout, (k % 2) ? 1'b1 : 1'b0);
            end
        end
        step();
        drop_reqs();
        repeat (2) step();

        // Consumer stall: result holds, no grants, next accept right after release.
        bus.out_ready = 1'b0;
        drive_req(0, 8'h03, 8'h04, 1'b0);
        wait_accept(0, ok);
        step();
        drive_req(0, 8'h01, 8'h01, 1'b0);
        drive_req(1, 8'h20, 8'h01, 1'b0);
        wait_valid(ok);
        for (int i = 0; i < 5; i++) begin
            check("stall_sum", bus.out_sum, 8'h07);
            check("stall_cout", bus.out_cout, 1'b0);
            check("stall_id", bus.out_id, 1'b0);
            check("stall_ready0", bus.req0_ready, 1'b0);
            check("stall_ready1", bus.req1_ready, 1'b0);
            if (i < 4) @(negedge clk);
        end
        step();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", bus.out_valid, 1'b1);
        @(negedge clk);
        check("after_take_valid", bus.out_valid, 1'b0);
        check("after_take_ready1", bus.req1_ready, 1'b1);
        step();
        drop_reqs();
        wait_valid(ok);
        if (ok) check("after_stall_sum", bus.out_sum, 8'h21);
        repeat (2) step();

        // Reset in the 4th ADD cycle after a req0 grant: op is dropped, req0 wins next conflict.
        drive_req(0, 8'h11, 8'h22, 1'b0);
        wait_accept(0, ok);
        step();
        drop_reqs();
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_valid", bus.out_valid, 1'b0);
        check("abort_state", dbg_state, 2'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_valid", bus.out_valid, 1'b0);
        end
        step();
        drive_req(0, 8'h01, 8'h02, 1'b0);
        drive_req(1, 8'h05, 8'h06, 1'b0);
        @(negedge clk);
        check("post_abort_ready0", bus.req0_ready, 1'b1);
        check("post_abort_ready1", bus.req1_ready, 1'b0);
        step();
        drop_reqs();
        wait_valid(ok);
        if (ok) begin
            check("post_abort_id", bus.out_id, 1'b0);
            check("post_abort_sum", bus.out_sum, 8'h03);
        end
        repeat (2) step();

        // Random traffic with consumer stalls; the monitor checks every cycle.
        target = ops_done + 1000;
        for (int c = 0; c < 40000 && ops_done < target; c++) begin
            step();
            bus.req0_valid = ($urandom_range(0, 9) < 7);
            bus.req0_a     = W'($urandom);
            bus.req0_b     = W'($urandom);
            bus.req0_cin   = 1'($urandom_range(0, 1));
            bus.req1_valid = ($urandom_range(0, 9) < 7);
            bus.req1_a     = W'($urandom);
            bus.req1_b     = W'($urandom);
            bus.req1_cin   = 1'($urandom_range(0, 1));
            bus.out_ready  = 1'($urandom_range(0, 1));
        end
        if (ops_done < target) begin
            n_vec++;
            n_err++;
            $display("FAIL random_timeout: %0d ops completed, expected %0d", ops_done, target);
        end
        step();
        drop_reqs();
        bus.out_ready = 1'b1;
        repeat (W + 4) step();
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
